// File: rtl/muldiv_if.sv
// Handshake and HI/LO access bundle between the pipeline and the sequential
// multiply/divide unit.
interface muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, X, Y, hi_we, lo_we, wdata,
    input  busy, done, div_zero, HI, LO
  );

  modport slave (
    input  start, op, X, Y, hi_we, lo_we, wdata,
    output busy, done, div_zero, HI, LO
  );
endinterface

// File: rtl/muldiv_unit.sv
// Sequential MULT/MULTU/DIV/DIVU engine with architectural HI/LO registers.
// Works on operand magnitudes for WIDTH iterations, then fixes signs in one extra cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic     clk,
  input logic     rst_n,
  muldiv_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  typedef enum logic [1:0] {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU} op_t;

  state_t           state;
  op_t              op_q;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] x_raw;
  logic             y_zero;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  // Operand conditioning, only meaningful while IDLE samples a start.
  logic             in_signed;
  logic             x_neg;
  logic             y_neg;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;

  always_comb begin
    in_signed = ~bus.op[0];
    x_neg     = in_signed & bus.X[WIDTH-1];
    y_neg     = in_signed & bus.Y[WIDTH-1];
    x_mag     = x_neg ? -bus.X : bus.X;
    y_mag     = y_neg ? -bus.Y : bus.Y;
  end

  // One iteration of either algorithm. The low half of acc starts as the
  // multiplier (shifted out LSB first) or the dividend (shifted out MSB first).
  logic             is_div;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [AW-1:0]    shl;
  logic [WIDTH:0]   trial;
  logic [AW-1:0]    div_next;
  logic [AW-1:0]    acc_next;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    is_div   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
    mul_next = {1'b0, mul_sum, acc[WIDTH-1:1]};
    shl      = acc << 1;
    // Partial remainder is < 2*divisor, so bit WIDTH of trial is the borrow.
    trial    = shl[AW-1:WIDTH] - {1'b0, b_mag};
    div_next = trial[WIDTH] ? shl : {trial, shl[WIDTH-1:1], 1'b1};
    acc_next = is_div ? div_next : mul_next;
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;

  always_comb begin
    prod = acc[2*WIDTH-1:0];
    quo  = acc[WIDTH-1:0];
    rem  = acc[2*WIDTH-1:WIDTH];
    if (neg_res) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_rem) begin
      rem = -rem;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= OP_MULT;
      cnt     <= '0;
      acc     <= '0;
      b_mag   <= '0;
      x_raw   <= '0;
      y_zero  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (bus.start) begin
            op_q    <= op_t'(bus.op);
            acc     <= {{(WIDTH+1){1'b0}}, x_mag};
            b_mag   <= y_mag;
            x_raw   <= bus.X;
            y_zero  <= (bus.Y == '0);
            neg_res <= x_neg ^ y_neg;
            neg_rem <= x_neg;
            dz_q    <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (cnt == CW'(WIDTH - 1)) begin
            state <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          if (is_div) begin
            if (y_zero) begin
              lo_q <= '1;
              hi_q <= x_raw;
              dz_q <= 1'b1;
            end else begin
              lo_q <= quo;
              hi_q <= rem;
            end
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.HI       = hi_q;
  assign bus.LO       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit against a plain-arithmetic
// reference model of MIPS HI/LO semantics.
module tb_muldiv_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic rst_n;

  muldiv_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Returns {div_zero, HI, LO} from the architectural definition.
  function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    longint      sx, sy, sq, sr;
    logic [63:0] hl;
    logic        dz;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    hl = '0;
    case (op)
      2'd0: hl = sx * sy;
      2'd1: hl = {32'b0, x} * {32'b0, y};
      default: begin
        if (y == 0) begin
          hl = {x, 32'hFFFF_FFFF};
          dz = 1'b1;
        end else if (op == 2'd2) begin
          sq = sx / sy;
          sr = sx % sy;
          hl = {sr[31:0], sq[31:0]};
        end else begin
          hl = {x % y, x / y};
        end
      end
    endcase
    return {dz, hl};
  endfunction

  task automatic idle_inputs();
    bus.start = 1'b0;
    bus.op    = 2'd0;
    bus.X     = '0;
    bus.Y     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    bus.start = 1'b1;
    bus.op    = op;
    bus.X     = x;
    bus.Y     = y;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // Waits for done with a bound, checking latency, busy, read-old behaviour and result.
  task automatic finish_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                           input logic [31:0] y, input bit disturb);
    logic [64:0] e;
    int          n;
    bit          busy_ok;
    e       = model(op, x, y);
    n       = 0;
    busy_ok = 1'b1;
    check({tag, ":busy_start"}, bus.busy, 1);
    while (!bus.done && n < 40) begin
      busy_ok &= bus.busy;
      if (disturb) begin
        if (n == 5) begin
          bus.start = 1'b1;
          bus.op    = 2'd1;
          bus.X     = 32'h0000_0003;
          bus.Y     = 32'h0000_0004;
        end else if (n == 6) begin
          bus.start = 1'b0;
        end else if (n == 10) begin
          bus.hi_we = 1'b1;
          bus.lo_we = 1'b1;
          bus.wdata = 32'h0000_1234;
        end else if (n == 11) begin
          bus.hi_we = 1'b0;
          bus.lo_we = 1'b0;
        end else if (n == 12) begin
          check({tag, ":hi_busy_hold"}, bus.HI, exp_hi);
          check({tag, ":lo_busy_hold"}, bus.LO, exp_lo);
        end
      end
      @(negedge clk);
      n++;
    end
    check({tag, ":latency"}, n, 33);
    check({tag, ":busy_held"}, busy_ok, 1);
    check({tag, ":busy_end"}, bus.busy, 0);
    check({tag, ":HI"}, bus.HI, e[63:32]);
    check({tag, ":LO"}, bus.LO, e[31:0]);
    check({tag, ":div_zero"}, bus.div_zero, e[64]);
    exp_hi = e[63:32];
    exp_lo = e[31:0];
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] x,
                       input logic [31:0] y, input bit b2b);
    if (!b2b) begin
      @(negedge clk);
      check({tag, ":done_drop"}, bus.done, 0);
    end
    launch(op, x, y);
    finish_op(tag, op, x, y, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit          seen_done;
    logic [1:0]  rop;
    logic [31:0] rx, ry;

    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("rst:HI", bus.HI, 0);
    check("rst:LO", bus.LO, 0);
    check("rst:busy", bus.busy, 0);
    check("rst:done", bus.done, 0);
    check("rst:div_zero", bus.div_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_op("multu_max", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max:const", {bus.HI, bus.LO}, 64'hFFFF_FFFE_0000_0001);
    do_op("mult_neg", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
    check("mult_neg:const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op("div_neg", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_neg:const", {bus.HI, bus.LO}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu_zero", 2'd3, 32'd7, 32'd0, 1'b0);
    check("divu_zero:const", {bus.div_zero, bus.HI, bus.LO}, {1'b1, 64'h0000_0007_FFFF_FFFF});

    @(negedge clk);
    launch(2'd3, 32'd100, 32'd7);
    check("divu_100_7:dz_clear", bus.div_zero, 0);
    finish_op("divu_100_7", 2'd3, 32'd100, 32'd7, 1'b0);
    check("divu_100_7:const", {bus.HI, bus.LO}, 64'h0000_0002_0000_000E);

    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf:const", {bus.div_zero, bus.HI, bus.LO}, {1'b0, 64'h0000_0000_8000_0000});
    do_op("div_neg_zero", 2'd2, 32'hFFFF_FFF0, 32'd0, 1'b0);

    // Start and mthi/mtlo while busy must not disturb the running MULT.
    @(negedge clk);
    launch(2'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    finish_op("mult_disturb", 2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    idle_inputs();

    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_ABCD;
    check("mthi", bus.HI, 32'h0000_1234);
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mtlo", bus.LO, 32'h0000_ABCD);
    check("mtlo:hi_kept", bus.HI, 32'h0000_1234);
    exp_hi = 32'h0000_1234;
    exp_lo = 32'h0000_ABCD;

    // mtlo alongside an accepted start lands, then the result overwrites it.
    bus.lo_we = 1'b1;
    bus.wdata = 32'h0000_5555;
    launch(2'd1, 32'd6, 32'd7);
    check("start_mtlo:lo_written", bus.LO, 32'h0000_5555);
    exp_lo = 32'h0000_5555;
    finish_op("start_mtlo", 2'd1, 32'd6, 32'd7, 1'b0);

    // Back-to-back: start presented in the done cycle.
    launch(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("b2b", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    // Reset in the middle of a DIVU.
    @(negedge clk);
    launch(2'd3, 32'hDEAD_BEEF, 32'd3);
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst:HI", bus.HI, 0);
    check("midrst:LO", bus.LO, 0);
    check("midrst:busy", bus.busy, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen_done |= bus.done;
    end
    check("midrst:no_done", seen_done, 0);
    check("midrst:HI_after", bus.HI, 0);
    exp_hi = '0;
    exp_lo = '0;
    do_op("after_rst", 2'd3, 32'hDEAD_BEEF, 32'd3, 1'b0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      rx  = pick();
      ry  = pick();
      do_op($sformatf("rnd%0d", i), rop, rx, ry, ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Sequential multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
- Complements the single-cycle ALU: long MULT/MULTU/DIV/DIVU work is moved off the combinational path and run as a 32-iteration engine behind a start/busy/done handshake.
- Results land in HI/LO, which mfhi/mflo read and mthi/mtlo write.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request an operation; sampled only in IDLE.
- op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- X  in  WIDTH  multiplicand / dividend.
- Y  in  WIDTH  multiplier / divisor.
- hi_we  in  1  mthi write enable.
- lo_we  in  1  mtlo write enable.
- wdata  in  WIDTH  mthi/mtlo data.
- busy  out  1  engine running; the pipeline stalls on HI/LO access while high.
- done  out  1  one-cycle pulse when HI/LO are updated by an operation.
- div_zero  out  1  last division had Y==0; held until the next accepted start.
- HI  out  WIDTH  HI register: product upper half / remainder.
- LO  out  WIDTH  LO register: product lower half / quotient.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; HI, LO, busy, done and div_zero all 0; iteration counter 0. Asserting reset mid-operation aborts the operation and leaves no partial HI/LO update.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Signed ops (0, 2): latch |X| and |Y|, plus result-sign flags. Unsigned ops (1, 3): latch X and Y raw.
  - Clear div_zero; counter=0; go to RUN; busy=1 after E0.
- RUN: one iteration per edge, E1..E32.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, producing a WIDTH-bit quotient and remainder.
  - After counter reaches WIDTH-1, go to FIX.
- FIX (edge E33): apply sign correction and write HI/LO; busy=0 and done=1 after E33; done returns to 0 after E34.
  - Signed product: negate the 2*WIDTH magnitude if sign(X)^sign(Y).
  - Signed quotient: negated if sign(X)^sign(Y).
  - Signed remainder: takes the sign of X.
  - Start-to-result latency is exactly 33 cycles, independent of operand values.
- Divide by zero: the full latency still elapses; at E33 LO=all-ones, HI=X (original, unsigned-reinterpreted), div_zero=1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0, div_zero=0.
- start while busy: ignored. No queueing, and no effect on the running operation.
- hi_we/lo_we:
  - IDLE: HI/LO take wdata at the edge.
  - busy (RUN/FIX): ignored.
  - Concurrent with an accepted start in IDLE: the write takes effect and is overwritten at E33.
- HI/LO are registered outputs; reads during busy return the old values.
- done and start in the same cycle (IDLE after FIX): the start is accepted normally, so back-to-back operations are possible every 34 cycles.
- All arithmetic is unsigned on magnitudes. The accumulator is 2*WIDTH+1 bits to hold the carry and the divide trial-subtract sign.

Test Plan:
- MULTU X=0xFFFFFFFF Y=0xFFFFFFFF -> busy high for 33 cycles; done pulse; HI=0xFFFFFFFE, LO=0x00000001.
- MULT X=0xFFFFFFFD (-3) Y=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1; then DIV X=0xFFFFFFF9 (-7) Y=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU X=7 Y=0 -> after 33 cycles LO=0xFFFFFFFF, HI=7, div_zero=1. Next DIVU X=100 Y=7 -> div_zero clears at start; LO=14, HI=2.
- DIV X=0x80000000 Y=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULT in progress, then: start with new operands at cycle 5 -> ignored, result unchanged; hi_we=1 wdata=0x1234 at cycle 10 -> ignored. In IDLE: hi_we=1 wdata=0x1234 -> HI=0x1234; lo_we=1 wdata=0xABCD -> LO=0xABCD.
- rst_n pulsed low at cycle 15 of a DIVU -> HI=LO=0, busy=0, done never pulses. A new start after reset completes correctly.
